std_mem_arb_d1: RTL and testbench
=================================

STD_MEM_ARB_D1 -- requirements
Module: std_mem_arb_d1

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 32, data width.
- SIZE, 16, memory depth.
- IDX_SIZE, 4, address width.
REQ-002 Ports SHALL be:
- clk  in  1  the only clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low; asserted while 0.
- go0, go1  in  1  access request per requester, level, held until the matching done.
- addr0_0, addr0_1  in  IDX_SIZE  requester address.
- write_data0, write_data1  in  WIDTH  requester write data.
- write_en0, write_en1  in  1  1 = write access, 0 = read access.
- read_data0, read_data1  out  WIDTH  captured read result.
- done0, done1  out  1  one-cycle completion pulse.
- mem_addr0  out  IDX_SIZE  to the shared memory.
- mem_write_data  out  WIDTH  to the shared memory.
- mem_write_en  out  1  to the shared memory.
- mem_read_data  in  WIDTH  combinational read from the shared memory.
- mem_done  in  1  registered write-done from the shared memory.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-004 In IDLE, when any go is 1, the block SHALL grant one requester; latch its address, write data and write_en into internal registers; and move to ISSUE. With no go asserted it SHALL stay in IDLE.
REQ-005 Arbitration SHALL be round-robin. With a single go, that requester is granted. With both go asserted, the requester not granted last is granted. The last-grant pointer updates only on a grant.
REQ-006 In ISSUE, mem_addr0 and mem_write_data SHALL come from the latched registers, and mem_write_en SHALL equal the latched write_en.
- Read: capture mem_read_data into the read register and move to DONE.
- Write: move to WAIT.
REQ-007 In WAIT, mem_addr0 SHALL be held and mem_write_en SHALL be 0. The FSM moves to DONE on the cycle mem_done is 1 and otherwise waits with no bound.
REQ-008 In DONE, the granted requester's done SHALL be 1 for exactly one cycle; the FSM then returns to IDLE.
REQ-009 read_data0 and read_data1 SHALL both show the read register. The value holds until the next read capture and is meaningful only on a read's done.
REQ-010 mem_write_en SHALL be 1 only in ISSUE of a write, giving exactly one memory write per granted write access.
REQ-011 Latency from the go cycle in IDLE to done SHALL be 2 cycles for a read and 3 cycles for a write, given mem_done one cycle after the write.
REQ-012 The block SHALL ignore go, address, data and write_en from either requester outside IDLE.
- Changes on the granted requester after the grant have no effect.
- A losing requester keeps go asserted and is served next.
REQ-013 The block SHALL never assert done0 and done1 in the same cycle, nor assert done to a requester that was not granted.
REQ-014 Back-to-back contention SHALL alternate grants, e.g. 0,1,0,1 while both go stay asserted.
REQ-015 In IDLE, mem_write_en SHALL be 0 and mem_addr0 and mem_write_data SHALL hold their last values.

Reset
REQ-016 While reset is 0, the block SHALL immediately force:
- state to IDLE;
- done0, done1 and mem_write_en to 0;
- the read register, latched address and latched data to 0;
- the last-grant pointer so that requester 0 wins the first tie.
REQ-017 Reset during ISSUE, WAIT or DONE SHALL abort the access without a done pulse. A write already issued is not undone.

Configuration
REQ-018 With macro STD_MEM_ARB_CHECK_EN defined, the block SHALL include simulation-only checks that call $error when:
- a latched address is >= SIZE at ISSUE;
- the granted requester drops go before its done;
- mem_done is 1 outside WAIT.
Without the macro, the checks SHALL be absent and behaviour SHALL be identical.

Verification
REQ-019 Single read: mem[5]=0xDEAD; go1=1, addr0_1=5, write_en1=0 at cycle 0 -> done1=1 at cycle 2, read_data1=0xDEAD, done0 stays 0.
REQ-020 Single write: go0=1, addr0_0=3, write_data0=0x1234, write_en0=1 -> mem_write_en=1 for one cycle (cycle 1) with mem_addr0=3; done0=1 at cycle 3; mem[3]=0x1234.
REQ-021 Tie after reset: go0=go1=1 at cycle 0, both reads -> done0 at cycle 2, done1 at cycle 5, with both go held until their done.
REQ-022 Fairness: both go held high for 4 accesses -> grant order 0,1,0,1, never two done pulses in one cycle.
REQ-023 Stalled write: mem_done delayed to 4 cycles after the write -> FSM stays in WAIT, done0 is 3 cycles later than in REQ-020, mem_write_en pulses only once.
REQ-024 Reset mid-WAIT: reset=0 for 1 cycle -> done0 and done1 stay 0, state is IDLE, the next tie grants requester 0.

Source files
------------

// File: rtl/std_mem_arb_d1.sv
// Two-requester round-robin arbiter sharing one memory port through an IDLE/ISSUE/WAIT/DONE FSM.
// Optional simulation-only protocol checks are enabled by defining STD_MEM_ARB_CHECK_EN.
module std_mem_arb_d1 #(
   parameter int WIDTH    = 32,
   parameter int SIZE     = 16,
   parameter int IDX_SIZE = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                go0,
   input  logic                go1,
   input  logic [IDX_SIZE-1:0] addr0_0,
   input  logic [IDX_SIZE-1:0] addr0_1,
   input  logic [WIDTH-1:0]    write_data0,
   input  logic [WIDTH-1:0]    write_data1,
   input  logic                write_en0,
   input  logic                write_en1,
   output logic [WIDTH-1:0]    read_data0,
   output logic [WIDTH-1:0]    read_data1,
   output logic                done0,
   output logic                done1,
   output logic [IDX_SIZE-1:0] mem_addr0,
   output logic [WIDTH-1:0]    mem_write_data,
   output logic                mem_write_en,
   input  logic [WIDTH-1:0]    mem_read_data,
   input  logic                mem_done
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t              r_state;
   logic                r_gnt;
   logic                r_last;
   logic [IDX_SIZE-1:0] r_addr;
   logic [WIDTH-1:0]    r_wdata;
   logic                r_we;
   logic [WIDTH-1:0]    r_rdata;
   logic                r_done0;
   logic                r_done1;
   logic                r_mem_we;

   logic                w_any;
   logic                w_pick;
   logic [IDX_SIZE-1:0] w_addr;
   logic [WIDTH-1:0]    w_wdata;
   logic                w_we;

   assign w_any   = go0 | go1;
   // On a tie the requester that was not served last wins.
   assign w_pick  = (go0 & go1) ? ~r_last : go1;
   assign w_addr  = w_pick ? addr0_1     : addr0_0;
   assign w_wdata = w_pick ? write_data1 : write_data0;
   assign w_we    = w_pick ? write_en1   : write_en0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_gnt    <= 1'b0;
         r_last   <= 1'b1;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_we     <= 1'b0;
         r_rdata  <= '0;
         r_done0  <= 1'b0;
         r_done1  <= 1'b0;
         r_mem_we <= 1'b0;
      end else begin
         r_done0  <= 1'b0;
         r_done1  <= 1'b0;
         r_mem_we <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_gnt    <= w_pick;
                  r_last   <= w_pick;
                  r_addr   <= w_addr;
                  r_wdata  <= w_wdata;
                  r_we     <= w_we;
                  r_mem_we <= w_we;
                  r_state  <= ISSUE;
               end
            end
            ISSUE: begin
               if (r_we) begin
                  r_state <= WAIT;
               end else begin
                  r_rdata <= mem_read_data;
                  r_done0 <= ~r_gnt;
                  r_done1 <= r_gnt;
                  r_state <= DONE;
               end
            end
            WAIT: begin
               if (mem_done) begin
                  r_done0 <= ~r_gnt;
                  r_done1 <= r_gnt;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // The latched request drives the memory port directly, so it holds in IDLE and WAIT.
   assign mem_addr0      = r_addr;
   assign mem_write_data = r_wdata;
   assign mem_write_en   = r_mem_we;
   assign read_data0     = r_rdata;
   assign read_data1     = r_rdata;
   assign done0          = r_done0;
   assign done1          = r_done1;

`ifdef STD_MEM_ARB_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         if (r_state == ISSUE && int'(r_addr) >= SIZE)
            $error("std_mem_arb_d1: latched address %0d out of range", r_addr);
         if ((r_state == ISSUE || r_state == WAIT) && !(r_gnt ? go1 : go0))
            $error("std_mem_arb_d1: requester %0d dropped go before done", r_gnt);
         if (mem_done && r_state != WAIT)
            $error("std_mem_arb_d1: mem_done seen outside WAIT");
      end
   end
`else
   // Depth only matters to the range check.
   logic w_unused_size;
   assign w_unused_size = (SIZE > 0);
`endif

endmodule

// File: tb/tb_std_mem_arb_d1.sv
// Scoreboard bench for std_mem_arb_d1: a schedule model predicts grant order, done cycles,
// read data and memory writes; monitors on the memory port and the done outputs check them.
module tb_std_mem_arb_d1;
   localparam int WIDTH    = 32;
   localparam int SIZE     = 16;
   localparam int IDX_SIZE = 4;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                go0 = 1'b0;
   logic                go1 = 1'b0;
   logic [IDX_SIZE-1:0] addr0_0 = '0;
   logic [IDX_SIZE-1:0] addr0_1 = '0;
   logic [WIDTH-1:0]    write_data0 = '0;
   logic [WIDTH-1:0]    write_data1 = '0;
   logic                write_en0 = 1'b0;
   logic                write_en1 = 1'b0;
   logic [WIDTH-1:0]    read_data0;
   logic [WIDTH-1:0]    read_data1;
   logic                done0;
   logic                done1;
   logic [IDX_SIZE-1:0] mem_addr0;
   logic [WIDTH-1:0]    mem_write_data;
   logic                mem_write_en;
   logic [WIDTH-1:0]    mem_read_data;
   logic                mem_done;

   always #5 clk = ~clk;

   std_mem_arb_d1 #(.WIDTH(WIDTH), .SIZE(SIZE), .IDX_SIZE(IDX_SIZE)) dut (
      .clk(clk), .reset(reset),
      .go0(go0), .go1(go1),
      .addr0_0(addr0_0), .addr0_1(addr0_1),
      .write_data0(write_data0), .write_data1(write_data1),
      .write_en0(write_en0), .write_en1(write_en1),
      .read_data0(read_data0), .read_data1(read_data1),
      .done0(done0), .done1(done1),
      .mem_addr0(mem_addr0), .mem_write_data(mem_write_data),
      .mem_write_en(mem_write_en), .mem_read_data(mem_read_data),
      .mem_done(mem_done)
   );

   typedef struct { bit we; logic [IDX_SIZE-1:0] addr; logic [WIDTH-1:0] data; int lat; } acc_t;
   typedef struct { int req; int cyc; bit rd; logic [WIDTH-1:0] data; } rsp_t;
   typedef struct { int cyc; logic [IDX_SIZE-1:0] addr; logic [WIDTH-1:0] data; } wr_t;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   md_cnt = 0;
   int   mem_lat = 1;
   logic mem_init = 1'b0;
   bit   model_last = 1'b1;

   logic [WIDTH-1:0] tb_mem  [SIZE];
   logic [WIDTH-1:0] ref_mem [SIZE];
   rsp_t sb[$];
   wr_t  wq[$];
   acc_t q0[$];
   acc_t q1[$];
   rsp_t r_exp;
   wr_t  w_exp;

   function automatic logic [WIDTH-1:0] init_val(input int i);
      return (i == 5) ? 32'h0000_DEAD : (32'hC0DE_0000 + 32'(i));
   endfunction

   function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic acc_t mk(input bit we, input int addr, input logic [WIDTH-1:0] data, input int lat);
      acc_t a;
      a.we = we;
      a.addr = IDX_SIZE'(addr);
      a.data = data;
      a.lat = lat;
      return a;
   endfunction

   function automatic acc_t rand_acc();
      return mk(1'($urandom_range(0, 1)), $urandom_range(0, SIZE - 1), $urandom, $urandom_range(1, 4));
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Shared memory: combinational read, write-done mem_lat cycles after the write pulse.
   assign mem_read_data = tb_mem[mem_addr0];
   assign mem_done      = (md_cnt == 1);

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         md_cnt <= 0;
      end else begin
         if (mem_init)
            for (int i = 0; i < SIZE; i++) tb_mem[i] <= init_val(i);
         if (mem_write_en) begin
            tb_mem[mem_addr0] <= mem_write_data;
            md_cnt <= mem_lat;
            if (wq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL wr_unexpected: got write addr %0d at cycle %0d, required none", mem_addr0, cyc);
            end else begin
               w_exp = wq.pop_front();
               check("wr_cycle", cyc, w_exp.cyc);
               check("wr_addr", mem_addr0, w_exp.addr);
               check("wr_data", mem_write_data, w_exp.data);
            end
         end else if (md_cnt > 0) begin
            md_cnt <= md_cnt - 1;
         end
      end
   end

   always @(negedge clk) begin
      if (reset && (done0 || done1)) begin
         $display("[TB] done cycle=%0d done0=%0b done1=%0b read_data=%h", cyc, done0, done1, read_data0);
         check("done_exclusive", done0 & done1, 0);
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL done_unexpected: got done at cycle %0d, required none", cyc);
         end else begin
            r_exp = sb.pop_front();
            check("done_req", done1, r_exp.req);
            check("done_cycle", cyc, r_exp.cyc);
            if (r_exp.rd) begin
               check("read_data0", read_data0, r_exp.data);
               check("read_data1", read_data1, r_exp.data);
            end
         end
      end
   end

   task automatic load(input int r, input acc_t a);
      if (r == 0) begin
         addr0_0 = a.addr; write_data0 = a.data; write_en0 = a.we;
      end else begin
         addr0_1 = a.addr; write_data1 = a.data; write_en1 = a.we;
      end
   endtask

   task automatic scramble(input int r);
      load(r, mk(1'($urandom_range(0, 1)), $urandom_range(0, SIZE - 1), $urandom, 1));
   endtask

   // Each requester holds go until its queued accesses are all done; the model walks the
   // round-robin rule over those queues to build the full schedule before driving.
   task automatic run_round();
      int   rq[$];
      acc_t ra[$];
      int   ts[$];
      int   td[$];
      int   i0, i1, n0, n1, t, w, lat, end_cyc;
      acc_t a;
      rsp_t rs;
      wr_t  wr;
      i0 = 0; i1 = 0; t = cyc;
      while (i0 < q0.size() || i1 < q1.size()) begin
         if (i0 < q0.size() && i1 < q1.size()) w = model_last ? 0 : 1;
         else w = (i0 < q0.size()) ? 0 : 1;
         model_last = (w == 1);
         if (w == 0) begin a = q0[i0]; i0++; end
         else begin a = q1[i1]; i1++; end
         lat = a.we ? 2 + a.lat : 2;
         rq.push_back(w); ra.push_back(a); ts.push_back(t); td.push_back(t + lat);
         rs.req = w; rs.cyc = t + lat; rs.rd = !a.we;
         rs.data = a.we ? '0 : ref_mem[a.addr];
         sb.push_back(rs);
         if (a.we) begin
            wr.cyc = t + 1; wr.addr = a.addr; wr.data = a.data;
            wq.push_back(wr);
            ref_mem[a.addr] = a.data;
         end
         t = t + lat + 1;
      end
      end_cyc = t;
      go0 = (q0.size() > 0);
      go1 = (q1.size() > 0);
      if (q0.size() > 0) load(0, q0[0]);
      if (q1.size() > 0) load(1, q1[0]);
      n0 = 1; n1 = 1;
      mem_lat = ra[0].lat;
      while (cyc < end_cyc) begin
         @(negedge clk);
         for (int k = 0; k < rq.size(); k++) begin
            if (cyc == ts[k]) mem_lat = ra[k].lat;
            if (cyc > ts[k] && cyc < td[k]) scramble(rq[k]);
            if (cyc == td[k]) begin
               if (rq[k] == 0) begin
                  if (n0 < q0.size()) begin load(0, q0[n0]); n0++; end
                  else go0 = 1'b0;
               end else begin
                  if (n1 < q1.size()) begin load(1, q1[n1]); n1++; end
                  else go1 = 1'b0;
               end
            end
         end
      end
      check("done_all_seen", sb.size(), 0);
      check("writes_all_seen", wq.size(), 0);
      check("idle_mem_we", mem_write_en, 0);
      sb.delete(); wq.delete(); q0.delete(); q1.delete();
   endtask

   task automatic reset_mid_wait();
      int t0;
      logic [WIDTH-1:0] d;
      wr_t wr;
      t0 = cyc;
      d = $urandom;
      load(0, mk(1'b1, 9, d, 1));
      go0 = 1'b1;
      mem_lat = 8;
      ref_mem[9] = d;
      wr.cyc = t0 + 1; wr.addr = 4'd9; wr.data = d;
      wq.push_back(wr);
      @(negedge clk);
      @(negedge clk);
      go0 = 1'b0;
      reset = 1'b0;
      #1;
      check("rst_done0", done0, 0);
      check("rst_done1", done1, 0);
      check("rst_mem_we", mem_write_en, 0);
      check("rst_mem_addr", mem_addr0, 0);
      check("rst_mem_wdata", mem_write_data, 0);
      check("rst_read_data", read_data0, 0);
      @(negedge clk);
      reset = 1'b1;
      model_last = 1'b1;
      repeat (10) @(negedge clk);
      check("rst_write_kept", wq.size(), 0);
      wq.delete();
   endtask

   initial begin
      int g, n;
      repeat (2) @(negedge clk);
      check("reset_done0", done0, 0);
      check("reset_done1", done1, 0);
      check("reset_mem_we", mem_write_en, 0);
      check("reset_mem_addr", mem_addr0, 0);
      check("reset_mem_wdata", mem_write_data, 0);
      check("reset_read_data0", read_data0, 0);
      check("reset_read_data1", read_data1, 0);
      reset = 1'b1;
      mem_init = 1'b1;
      for (int i = 0; i < SIZE; i++) ref_mem[i] = init_val(i);
      @(negedge clk);
      mem_init = 1'b0;
      repeat (2) @(negedge clk);

      // Tie after reset: requester 0 first, then 1.
      q0.push_back(mk(1'b0, 2, '0, 1));
      q1.push_back(mk(1'b0, 7, '0, 1));
      run_round();
      // Both held for two accesses each: 0,1,0,1.
      q0.push_back(mk(1'b0, 1, '0, 1)); q0.push_back(mk(1'b0, 4, '0, 1));
      q1.push_back(mk(1'b0, 6, '0, 1)); q1.push_back(mk(1'b0, 8, '0, 1));
      run_round();
      // Single read of the preloaded 0xDEAD.
      q1.push_back(mk(1'b0, 5, '0, 1));
      run_round();
      // Single write, then a write whose mem_done is stalled.
      q0.push_back(mk(1'b1, 3, 32'h0000_1234, 1));
      run_round();
      q0.push_back(mk(1'b1, 12, 32'h0BAD_BEEF, 4));
      run_round();
      q1.push_back(mk(1'b0, 3, '0, 1));
      run_round();

      reset_mid_wait();
      q0.push_back(mk(1'b1, 10, 32'hAAAA_0001, 2));
      q1.push_back(mk(1'b1, 11, 32'hBBBB_0002, 1));
      run_round();

      for (int r = 0; r < 40; r++) begin
         g = $urandom_range(1, 3);
         if (g[0]) begin
            n = $urandom_range(1, 2);
            for (int j = 0; j < n; j++) q0.push_back(rand_acc());
         end
         if (g[1]) begin
            n = $urandom_range(1, 2);
            for (int j = 0; j < n; j++) q1.push_back(rand_acc());
         end
         run_round();
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      @(negedge clk);
      for (int i = 0; i < SIZE; i++) check("mem_final", tb_mem[i], ref_mem[i]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no end of run by time %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
